// File: rtl/omem_readback_sched_pkg.sv
// Shared widths and readback FSM state encodings for the OMEM readback scheduler.
package omem_readback_sched_pkg;

  localparam int WB_WIDTH      = 32;
  localparam int MAX_CORES     = 4;
  localparam int MAX_CORE_BITS = 2;

  typedef enum logic [1:0] {
    RBS_IDLE  = 2'd0,
    RBS_ISSUE = 2'd1,
    RBS_DRAIN = 2'd2
  } rbs_state_t;

endpackage

// File: rtl/omem_rb_fifo.sv
// Small synchronous FIFO buffering OMEM read returns; head entry is visible combinationally.
module omem_rb_fifo
  import omem_readback_sched_pkg::*;
#(
  parameter int WIDTH = 66,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observable while count covers them.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // The scheduler's credit scheme must never let a push land on a full FIFO.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/omem_readback_sched.sv
// Drains per-core OMEM banks after a render pass into a tagged valid/ready stream.
// Optional READBACK_CHECKSUM_EN adds oChecksum, a running sum of popped beat data.
module omem_readback_sched
  import omem_readback_sched_pkg::*;
#(
  parameter int DATA_W     = WB_WIDTH,
  parameter int ADDR_W     = WB_WIDTH,
  parameter int CORES      = MAX_CORES,
  parameter int CORE_BITS  = MAX_CORE_BITS,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iStart,
  input  logic                 iAbort,
  input  logic [CORES-1:0]     iCoreMask,
  input  logic [ADDR_W-1:0]    iWordsPerCore,
  output logic [CORE_BITS-1:0] oOMEMBankSelect,
  output logic [ADDR_W-1:0]    oOMEMReadAddress,
  input  logic [DATA_W-1:0]    iOMEMData,
  output logic                 oValid,
  input  logic                 iReady,
  output logic [DATA_W-1:0]    oData,
  output logic [CORE_BITS-1:0] oCoreId,
  output logic [ADDR_W-1:0]    oWordAddr,
  output logic                 oBusy,
  output logic                 oDone
`ifdef READBACK_CHECKSUM_EN
  , output logic [DATA_W-1:0]  oChecksum
`endif
);

  localparam int ENTRY_W = DATA_W + CORE_BITS + ADDR_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W   = 16;

  rbs_state_t state;
  logic [CORES-1:0]     mask_q;
  logic [ADDR_W-1:0]    count_q;
  logic [RD_LAT-1:0]    tag_valid;
  logic [CORE_BITS-1:0] tag_core [RD_LAT];
  logic [ADDR_W-1:0]    tag_addr [RD_LAT];

  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_empty;
  logic [ENTRY_W-1:0]   fifo_head;
  logic [DATA_W-1:0]    head_data;
  logic [CORE_BITS-1:0] head_core;
  logic [ADDR_W-1:0]    head_addr;
  logic [OCC_W-1:0]     inflight;
  logic [OCC_W-1:0]     occupancy;
  logic [CORE_BITS-1:0] first_core;
  logic [CORE_BITS-1:0] next_core;
  logic                 next_found;
  logic                 issue;
  logic                 push;
  logic                 pop;
  logic                 drained;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + OCC_W'(tag_valid[i]);
  end

  // Lowest set bit of the incoming mask, and the next set bit above the current bank.
  always_comb begin
    first_core = '0;
    next_core  = '0;
    next_found = 1'b0;
    for (int i = CORES - 1; i >= 0; i--) begin
      if (iCoreMask[i]) first_core = CORE_BITS'(i);
      if (mask_q[i] && (i > int'(oOMEMBankSelect))) begin
        next_core  = CORE_BITS'(i);
        next_found = 1'b1;
      end
    end
  end

  assign occupancy = OCC_W'(fifo_count) + inflight;
  assign issue     = (state == RBS_ISSUE) && !iAbort && (occupancy < OCC_W'(FIFO_DEPTH));
  assign push      = tag_valid[RD_LAT-1] && !iAbort;
  assign pop       = oValid && iReady;
  assign drained   = (inflight == '0) &&
                     (fifo_empty || ((fifo_count == CNT_W'(1)) && pop));

  assign {head_data, head_core, head_addr} = fifo_head;
  assign oValid    = !fifo_empty;
  assign oData     = fifo_empty ? '0 : head_data;
  assign oCoreId   = fifo_empty ? '0 : head_core;
  assign oWordAddr = fifo_empty ? '0 : head_addr;
  assign oBusy     = (state != RBS_IDLE);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state            <= RBS_IDLE;
      mask_q           <= '0;
      count_q          <= '0;
      oOMEMBankSelect  <= '0;
      oOMEMReadAddress <= '0;
      oDone            <= 1'b0;
    end else begin
      oDone <= 1'b0;
      if (iAbort) begin
        state <= RBS_IDLE;
      end else begin
        case (state)
          RBS_IDLE: if (iStart) begin
            mask_q           <= iCoreMask;
            count_q          <= iWordsPerCore;
            oOMEMBankSelect  <= first_core;
            oOMEMReadAddress <= '0;
            state <= ((iCoreMask == '0) || (iWordsPerCore == '0)) ? RBS_DRAIN : RBS_ISSUE;
          end
          RBS_ISSUE: if (issue) begin
            if (oOMEMReadAddress == count_q - 1'b1) begin
              if (next_found) begin
                oOMEMBankSelect  <= next_core;
                oOMEMReadAddress <= '0;
              end else begin
                state <= RBS_DRAIN;
              end
            end else begin
              oOMEMReadAddress <= oOMEMReadAddress + 1'b1;
            end
          end
          RBS_DRAIN: if (drained) begin
            oDone <= 1'b1;
            state <= RBS_IDLE;
          end
          default: state <= RBS_IDLE;
        endcase
      end
    end
  end

  // Tags follow each read for RD_LAT cycles so returning data can be labelled.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      tag_valid <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_core[i] <= '0;
        tag_addr[i] <= '0;
      end
    end else begin
      tag_valid[0] <= issue;
      tag_core[0]  <= oOMEMBankSelect;
      tag_addr[0]  <= oOMEMReadAddress;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_core[i]  <= tag_core[i-1];
        tag_addr[i]  <= tag_addr[i-1];
      end
      if (iAbort) tag_valid <= '0;
    end
  end

  omem_rb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (Clock),
    .rst_n     (Reset),
    .flush     (iAbort),
    .push      (push),
    .push_data ({iOMEMData, tag_core[RD_LAT-1], tag_addr[RD_LAT-1]}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

`ifdef READBACK_CHECKSUM_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oChecksum <= '0;
    end else if (iAbort || ((state == RBS_IDLE) && iStart)) begin
      oChecksum <= '0;
    end else if (pop) begin
      oChecksum <= oChecksum + oData;
    end
  end
`endif

endmodule

// File: tb/tb_omem_readback_sched.sv
// Directed bench for omem_readback_sched with a one-cycle-latency OMEM model.
// Checksum checks are compiled in only when READBACK_CHECKSUM_EN is defined.
module tb_omem_readback_sched;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  core;
    logic [31:0] addr;
    int          cyc;
  } beat_t;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iStart;
  logic        iAbort;
  logic [3:0]  iCoreMask;
  logic [31:0] iWordsPerCore;
  logic [1:0]  oOMEMBankSelect;
  logic [31:0] oOMEMReadAddress;
  logic [31:0] iOMEMData = '0;
  logic        oValid;
  logic        iReady;
  logic [31:0] oData;
  logic [1:0]  oCoreId;
  logic [31:0] oWordAddr;
  logic        oBusy;
  logic        oDone;
`ifdef READBACK_CHECKSUM_EN
  logic [31:0] oChecksum;
  logic [31:0] done_sum = '0;
`endif

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    start_cyc = 0;
  int    done_cnt = 0;
  int    done_cyc = 0;
  int    overlap_cnt = 0;
  int    data_mode = 0;
  beat_t beats[$];

  omem_readback_sched dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .iStart           (iStart),
    .iAbort           (iAbort),
    .iCoreMask        (iCoreMask),
    .iWordsPerCore    (iWordsPerCore),
    .oOMEMBankSelect  (oOMEMBankSelect),
    .oOMEMReadAddress (oOMEMReadAddress),
    .iOMEMData        (iOMEMData),
    .oValid           (oValid),
    .iReady           (iReady),
    .oData            (oData),
    .oCoreId          (oCoreId),
    .oWordAddr        (oWordAddr),
    .oBusy            (oBusy),
    .oDone            (oDone)
`ifdef READBACK_CHECKSUM_EN
    , .oChecksum      (oChecksum)
`endif
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc++;

  function automatic logic [31:0] expData(input logic [1:0] c, input logic [31:0] a);
    if (data_mode == 1) return a + 32'd1;
    return 32'hC000_0000 | (32'(c) << 20) | (a & 32'h0000_FFFF);
  endfunction

  // OMEM model: data for the presented bank/address is valid one cycle later.
  always @(posedge Clock) iOMEMData <= expData(oOMEMBankSelect, oOMEMReadAddress);

  always @(negedge Clock) begin
    if (oValid && iReady) beats.push_back('{data: oData, core: oCoreId, addr: oWordAddr, cyc: cyc});
    if (oDone) begin
      done_cnt++;
      done_cyc = cyc;
`ifdef READBACK_CHECKSUM_EN
      done_sum = oChecksum;
`endif
    end
    if (oDone && oValid) overlap_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input logic [31:0] words);
    @(posedge Clock);
    #1;
    beats.delete();
    done_cnt      = 0;
    iCoreMask     = mask;
    iWordsPerCore = words;
    iStart        = 1'b1;
    start_cyc     = cyc;
    @(posedge Clock);
    #1;
    iStart = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    for (int i = 0; i < 200 && done_cnt == 0; i++) @(posedge Clock);
    repeat (3) @(posedge Clock);
    checkOutput({tag, "_done_once"}, done_cnt, 1);
    checkOutput({tag, "_idle"}, oBusy, 0);
  endtask

  task automatic checkBeats(input string tag, input logic [3:0] mask, input int words);
    int k = 0;
    int n = 0;
    for (int c = 0; c < 4; c++) if (mask[c]) n += words;
    checkOutput({tag, "_beats"}, beats.size(), n);
    for (int c = 0; c < 4; c++) begin
      if (mask[c]) begin
        for (int a = 0; a < words; a++) begin
          if (k < beats.size()) begin
            checkOutput($sformatf("%s_b%0d_core", tag, k), beats[k].core, c);
            checkOutput($sformatf("%s_b%0d_addr", tag, k), beats[k].addr, a);
            checkOutput($sformatf("%s_b%0d_data", tag, k), beats[k].data, expData(2'(c), 32'(a)));
          end
          k++;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset = 1'b0; iStart = 1'b0; iAbort = 1'b0; iCoreMask = '0; iWordsPerCore = '0; iReady = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    checkOutput("rst_valid", oValid, 0);
    checkOutput("rst_busy", oBusy, 0);
    checkOutput("rst_done", oDone, 0);
    checkOutput("rst_bank", oOMEMBankSelect, 0);
    checkOutput("rst_addr", oOMEMReadAddress, 0);
    checkOutput("rst_data", oData, 0);
    Reset = 1'b1;

    // All four banks, three words each, sink always ready.
    applyStimulus(4'b1111, 32'd3);
    waitDone("t1");
    checkBeats("t1", 4'b1111, 3);
    if (beats.size() == 12) begin
      checkOutput("t1_first_cyc", beats[0].cyc, start_cyc + 3);
      checkOutput("t1_last_cyc", beats[11].cyc, start_cyc + 14);
      checkOutput("t1_done_cyc", done_cyc, beats[11].cyc + 1);
    end

    // Sparse mask; a second iStart mid-run must be ignored.
    applyStimulus(4'b0101, 32'd2);
    @(posedge Clock);
    #1;
    iCoreMask = 4'b1111;
    iStart    = 1'b1;
    @(posedge Clock);
    #1;
    iStart = 1'b0;
    waitDone("t2");
    checkBeats("t2", 4'b0101, 2);
    if (beats.size() == 4) checkOutput("t2_nogap", beats[2].cyc, beats[1].cyc + 1);

    // Back-pressure: only FIFO_DEPTH reads issue, head beat held stable.
    iReady = 1'b0;
    applyStimulus(4'b0001, 32'd8);
    repeat (8) @(posedge Clock);
    @(negedge Clock);
    checkOutput("t3_stall_addr", oOMEMReadAddress, 4);
    checkOutput("t3_stall_valid", oValid, 1);
    checkOutput("t3_stall_data", oData, expData(2'd0, 32'd0));
    @(negedge Clock);
    checkOutput("t3_hold_data", oData, expData(2'd0, 32'd0));
    checkOutput("t3_hold_addr", oWordAddr, 0);
    @(posedge Clock);
    #1;
    iReady = 1'b1;
    waitDone("t3");
    checkBeats("t3", 4'b0001, 8);

    // Nothing to read: oDone two cycles after the iStart cycle.
    applyStimulus(4'b0000, 32'd3);
    waitDone("t4a");
    checkOutput("t4a_done_cyc", done_cyc, start_cyc + 2);
    checkOutput("t4a_beats", beats.size(), 0);
    applyStimulus(4'b1111, 32'd0);
    waitDone("t4b");
    checkOutput("t4b_done_cyc", done_cyc, start_cyc + 2);
    checkOutput("t4b_beats", beats.size(), 0);

    // Abort mid-run, then a fresh run from the lowest set bank.
    applyStimulus(4'b1111, 32'd3);
    for (int i = 0; i < 50 && beats.size() < 3; i++) @(posedge Clock);
    #1;
    iAbort = 1'b1;
    @(posedge Clock);
    #1;
    iAbort = 1'b0;
    @(negedge Clock);
    checkOutput("t5_valid_after_abort", oValid, 0);
    checkOutput("t5_busy_after_abort", oBusy, 0);
    repeat (5) @(posedge Clock);
    checkOutput("t5_no_done", done_cnt, 0);
    applyStimulus(4'b0110, 32'd2);
    waitDone("t5");
    checkBeats("t5", 4'b0110, 2);
    if (beats.size() > 0) checkOutput("t5_first_cyc", beats[0].cyc, start_cyc + 3);

`ifdef READBACK_CHECKSUM_EN
    data_mode = 1;
    applyStimulus(4'b0001, 32'd4);
    waitDone("t6");
    checkBeats("t6", 4'b0001, 4);
    checkOutput("t6_checksum", done_sum, 10);
    data_mode = 0;
`endif

    // Asynchronous reset in the middle of a stalled run.
    iReady = 1'b0;
    applyStimulus(4'b1111, 32'd3);
    repeat (3) @(posedge Clock);
    #3;
    Reset = 1'b0;
    #1;
    checkOutput("t7_valid", oValid, 0);
    checkOutput("t7_data", oData, 0);
    checkOutput("t7_busy", oBusy, 0);
    checkOutput("t7_bank", oOMEMBankSelect, 0);
    checkOutput("t7_addr", oOMEMReadAddress, 0);
    checkOutput("t7_done", oDone, 0);
`ifdef READBACK_CHECKSUM_EN
    checkOutput("t7_checksum", oChecksum, 0);
`endif
    @(posedge Clock);
    #1;
    Reset  = 1'b1;
    iReady = 1'b1;
    applyStimulus(4'b1000, 32'd2);
    waitDone("t7");
    checkBeats("t7", 4'b1000, 2);

    checkOutput("done_with_valid", overlap_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
